// File: rtl/xgmii_pkg.sv
// Shared XGMII constants, FSM state encoding and AXI-Stream beat payload for the RX deframer.
package xgmii_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned STAT_W = 32;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  localparam logic [DATA_W-1:0] PREAMBLE_WORD = {8'h55, 8'h55, 8'h55, XGMII_START};
  localparam logic [CTRL_W-1:0] PREAMBLE_CTRL = 4'b0001;
  localparam logic [DATA_W-1:0] SFD_WORD      = 32'hD555_5555;
  localparam logic [CTRL_W-1:0] SFD_CTRL      = 4'b0000;
  localparam logic [DATA_W-1:0] IDLE_WORD     = {4{XGMII_IDLE}};
  localparam logic [CTRL_W-1:0] IDLE_CTRL     = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic              last;
    logic              user;
    logic [CTRL_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } axis_beat_t;

  function automatic axis_beat_t mk_beat(input logic [DATA_W-1:0] data,
                                         input logic [CTRL_W-1:0] keep,
                                         input logic last, input logic user);
    axis_beat_t b;
    b.data = data;
    b.keep = keep;
    b.last = last;
    b.user = user;
    return b;
  endfunction

  // Byte mask covering the lanes below the terminate lane.
  function automatic logic [CTRL_W-1:0] lane_keep(input logic [1:0] lane);
    logic [CTRL_W-1:0] k;
    case (lane)
      2'd1:    k = 4'b0001;
      2'd2:    k = 4'b0011;
      2'd3:    k = 4'b0111;
      default: k = 4'b0000;
    endcase
    return k;
  endfunction

  function automatic logic [DATA_W-1:0] mask_data(input logic [DATA_W-1:0] data,
                                                  input logic [CTRL_W-1:0] keep);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < int'(LANES); k++) begin
      d[8*k +: 8] = keep[k] ? data[8*k +: 8] : 8'h00;
    end
    return d;
  endfunction

endpackage

// File: rtl/xgmii_term_detect.sv
// Finds the lowest control lane of an XGMII word and classifies it as terminate or bad control.
module xgmii_term_detect
  import xgmii_pkg::*;
(
  input  logic [DATA_W-1:0] rxd_i,
  input  logic [CTRL_W-1:0] rxc_i,
  output logic              term_found_o,
  output logic [1:0]        term_lane_o,
  output logic              bad_ctrl_o
);

  logic       ctrl_seen;
  logic [1:0] first_lane;
  logic [7:0] first_byte;

  always_comb begin
    ctrl_seen  = 1'b0;
    first_lane = 2'd0;
    // Scan downwards so the lowest control lane wins.
    for (int k = int'(LANES) - 1; k >= 0; k--) begin
      if (rxc_i[k]) begin
        ctrl_seen  = 1'b1;
        first_lane = 2'(k);
      end
    end
    first_byte   = rxd_i[{first_lane, 3'b000} +: 8];
    term_found_o = ctrl_seen && (first_byte == XGMII_TERM);
    bad_ctrl_o   = ctrl_seen && (first_byte != XGMII_TERM);
    term_lane_o  = first_lane;
  end

endmodule

// File: rtl/xgmii_rx_deframer.sv
// XGMII RX deframer: strips preamble/SFD and emits payload as an unstalled AXI-Stream.
// Optional frame/error statistics ports are enabled with `define XGMII_RX_STATS_EN.
module xgmii_rx_deframer
  import xgmii_pkg::*;
#(
  parameter int unsigned MAX_FRAME_WORDS = 380
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_xgmii_rxd,
  input  logic [CTRL_W-1:0] i_xgmii_rxc,
  input  logic              i_rx_valid,
  output logic [DATA_W-1:0] o_axis_tdata,
  output logic [CTRL_W-1:0] o_axis_tkeep,
  output logic              o_axis_tvalid,
  output logic              o_axis_tlast,
  output logic              o_axis_tuser
`ifdef XGMII_RX_STATS_EN
  ,
  output logic [STAT_W-1:0] o_frame_count,
  output logic [STAT_W-1:0] o_error_count
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_FRAME_WORDS + 2);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  axis_beat_t        pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  axis_beat_t        out_q, out_d;
  logic              out_vld_q, out_vld_d;
  logic              error_evt_c;
  logic              frame_evt_c;

  logic       term_found;
  logic [1:0] term_lane;
  logic       bad_ctrl;
  logic       is_start, is_sfd, is_idle, is_data, has_term, overflow;
  axis_beat_t partial;

  xgmii_term_detect u_term_detect (
    .rxd_i        (i_xgmii_rxd),
    .rxc_i        (i_xgmii_rxc),
    .term_found_o (term_found),
    .term_lane_o  (term_lane),
    .bad_ctrl_o   (bad_ctrl)
  );

  // Word classification shared by all states.
  always_comb begin
    is_start = (i_xgmii_rxc == PREAMBLE_CTRL) && (i_xgmii_rxd == PREAMBLE_WORD);
    is_sfd   = (i_xgmii_rxc == SFD_CTRL) && (i_xgmii_rxd == SFD_WORD);
    is_idle  = (i_xgmii_rxc == IDLE_CTRL) && (i_xgmii_rxd == IDLE_WORD);
    is_data  = (i_xgmii_rxc == '0);
    overflow = is_data && (cnt_q == CNT_W'(MAX_FRAME_WORDS));
    has_term = 1'b0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (i_xgmii_rxc[k] && (i_xgmii_rxd[8*k +: 8] == XGMII_TERM)) begin
        has_term = 1'b1;
      end
    end
    partial = mk_beat(mask_data(i_xgmii_rxd, lane_keep(term_lane)),
                      lane_keep(term_lane), 1'b1, 1'b0);
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    cnt_d       = cnt_q;
    pend_d      = '0;
    pend_vld_d  = 1'b0;
    out_d       = '0;
    out_vld_d   = 1'b0;
    error_evt_c = 1'b0;

    // A partial tail beat queued by the previous terminate goes out first.
    if (pend_vld_q) begin
      out_vld_d = 1'b1;
      out_d     = pend_q;
    end

    if (i_rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (is_start) state_d = ST_PREAMBLE;
        end
        ST_PREAMBLE: begin
          if (is_sfd) begin
            state_d    = ST_DATA;
            hold_vld_d = 1'b0;
            cnt_d      = '0;
          end else begin
            state_d     = ST_IDLE;
            error_evt_c = 1'b1;
          end
        end
        ST_DATA: begin
          if (is_start || bad_ctrl || overflow) begin
            error_evt_c = 1'b1;
            hold_vld_d  = 1'b0;
            if (hold_vld_q) begin
              out_vld_d = 1'b1;
              out_d     = mk_beat(hold_q, 4'hF, 1'b1, 1'b1);
            end
            state_d = is_start ? ST_PREAMBLE : ST_DRAIN;
          end else if (is_data) begin
            if (hold_vld_q) begin
              out_vld_d = 1'b1;
              out_d     = mk_beat(hold_q, 4'hF, 1'b0, 1'b0);
            end
            hold_d     = i_xgmii_rxd;
            hold_vld_d = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
          end else if (term_found) begin
            state_d    = ST_IDLE;
            hold_vld_d = 1'b0;
            if (term_lane == 2'd0) begin
              if (hold_vld_q) begin
                out_vld_d = 1'b1;
                out_d     = mk_beat(hold_q, 4'hF, 1'b1, 1'b0);
              end else begin
                error_evt_c = 1'b1;
              end
            end else if (hold_vld_q) begin
              out_vld_d  = 1'b1;
              out_d      = mk_beat(hold_q, 4'hF, 1'b0, 1'b0);
              pend_vld_d = 1'b1;
              pend_d     = partial;
            end else begin
              out_vld_d = 1'b1;
              out_d     = partial;
            end
          end
        end
        ST_DRAIN: begin
          if (has_term || is_idle) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    frame_evt_c = out_vld_d && out_d.last && !out_d.user;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign o_axis_tdata  = out_q.data;
  assign o_axis_tkeep  = out_q.keep;
  assign o_axis_tlast  = out_q.last;
  assign o_axis_tuser  = out_q.user;
  assign o_axis_tvalid = out_vld_q;

`ifdef XGMII_RX_STATS_EN
  logic [STAT_W-1:0] frame_cnt_q, err_cnt_q;

  // Free-running statistics; both counters wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_evt_c) frame_cnt_q <= frame_cnt_q + STAT_W'(1);
      if (error_evt_c) err_cnt_q   <= err_cnt_q + STAT_W'(1);
    end
  end

  assign o_frame_count = frame_cnt_q;
  assign o_error_count = err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{error_evt_c, frame_evt_c};
`endif

endmodule

// File: tb/tb_xgmii_rx_deframer.sv
// Directed bench for xgmii_rx_deframer; statistics checks are active when XGMII_RX_STATS_EN is defined.
module tb_xgmii_rx_deframer;

  localparam int MAXW = 380;
  localparam logic [31:0] W_START = 32'h5555_55FB;
  localparam logic [31:0] W_SFD   = 32'hD555_5555;
  localparam logic [31:0] W_IDLE  = 32'h0707_0707;
  localparam logic [31:0] W_TERM0 = 32'h0707_07FD;

  typedef logic [37:0] beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rxd = '0;
  logic [3:0]  rxc = '0;
  logic        vld = 1'b0;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast, tuser;
`ifdef XGMII_RX_STATS_EN
  logic [31:0] frame_count, error_count;
`endif

  int    tests_run = 0;
  int    tests_failed = 0;
  int    exp_err = 0;
  int    exp_frm = 0;
  int    cyc = 0;
  beat_t got[$];
  int    got_cyc[$];
  beat_t exp[$];

  xgmii_rx_deframer dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_xgmii_rxd   (rxd),
    .i_xgmii_rxc   (rxc),
    .i_rx_valid    (vld),
    .o_axis_tdata  (tdata),
    .o_axis_tkeep  (tkeep),
    .o_axis_tvalid (tvalid),
    .o_axis_tlast  (tlast),
    .o_axis_tuser  (tuser)
`ifdef XGMII_RX_STATS_EN
    ,
    .o_frame_count (frame_count),
    .o_error_count (error_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every beat; tuser must be low on non-last beats.
  always @(negedge clk) begin
    if (tvalid) begin
      got.push_back({tlast, tuser, tkeep, tdata});
      got_cyc.push_back(cyc);
      if (!tlast) begin
        tests_run++;
        if (tuser !== 1'b0) begin
          tests_failed++;
          $display("FAIL tuser_nonlast: tuser=%b on non-last beat data=%08h", tuser, tdata);
        end
      end
    end
  end

  function automatic logic [31:0] pay(input int i);
    if (i == 15) return 32'h79F7_EB93;
    return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
  endfunction

  function automatic beat_t bt(input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic u);
    return {l, u, k, d};
  endfunction

  task automatic exp_full(input int n, input bit close, input bit err);
    for (int i = 0; i < n; i++)
      exp.push_back(bt(pay(i), 4'hF, close && (i == n-1), err && (i == n-1)));
  endtask

  task automatic drv(input logic [31:0] d, input logic [3:0] c, input logic v);
    @(negedge clk);
    rxd = d; rxc = c; vld = v;
  endtask

  task automatic put(input logic [31:0] d, input logic [3:0] c, input bit gap);
    drv(d, c, 1'b1);
    if (gap) drv(32'hDEAD_BEEF, 4'hF, 1'b0);
  endtask

  task automatic idles(input int n);
    repeat (n) put(W_IDLE, 4'hF, 1'b0);
  endtask

  task automatic send_frame(input int n, input logic [31:0] td, input logic [3:0] tc,
                            input bit gap);
    idles(2);
    put(W_START, 4'b0001, gap);
    put(W_SFD, 4'b0000, gap);
    for (int i = 0; i < n; i++) put(pay(i), 4'b0000, gap);
    put(td, tc, gap);
    idles(3);
  endtask

  task automatic start_test();
    got.delete(); got_cyc.delete(); exp.delete();
  endtask

  task automatic test_reset();
    start_test();
    rst = 1'b1;
    drv(W_START, 4'b0001, 1'b1);
    drv(W_SFD, 4'b0000, 1'b1);
    @(negedge clk);
    tests_run += 5;
    if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    if (tlast  !== 1'b0) begin tests_failed++; $display("FAIL reset_tlast: got %b want 0", tlast); end
    if (tuser  !== 1'b0) begin tests_failed++; $display("FAIL reset_tuser: got %b want 0", tuser); end
    if (tkeep  !== 4'h0) begin tests_failed++; $display("FAIL reset_tkeep: got %h want 0", tkeep); end
    if (tdata  !== 32'h0) begin tests_failed++; $display("FAIL reset_tdata: got %h want 0", tdata); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) put(pay(i), 4'b0000, 1'b0);
    put(W_TERM0, 4'hF, 1'b0);
    idles(3);
    tests_run++;
    if (got.size() !== 0) begin
      tests_failed++;
      $display("FAIL reset_ignores_input: got %0d beats want 0", got.size());
    end
`ifdef XGMII_RX_STATS_EN
    tests_run++;
    if (error_count !== 32'(exp_err) || frame_count !== 32'(exp_frm)) begin
      tests_failed++;
      $display("FAIL reset_counters: err=%0d frm=%0d want 0 0", error_count, frame_count);
    end
`endif
  endtask

  task automatic test_frame64();
    start_test();
    send_frame(16, W_TERM0, 4'hF, 1'b0);
    exp_full(16, 1'b1, 1'b0);
    exp_frm++;
    tests_run++;
    if (got.size() !== exp.size()) begin
      tests_failed++; $display("FAIL frame64_count: got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== exp[i]) begin
        tests_failed++; $display("FAIL frame64_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_partial_term();
    start_test();
    send_frame(16, 32'h07FD_BEEF, 4'b1100, 1'b0);
    exp_full(16, 1'b0, 1'b0);
    exp.push_back(bt(32'h0000_BEEF, 4'b0011, 1'b1, 1'b0));
    exp_frm++;
    tests_run++;
    if (got.size() !== exp.size()) begin
      tests_failed++; $display("FAIL partial_count: got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== exp[i]) begin
        tests_failed++; $display("FAIL partial_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_error_ctrl();
    start_test();
    idles(2);
    put(W_START, 4'b0001, 1'b0);
    put(W_SFD, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) put(pay(i), 4'b0000, 1'b0);
    put(32'h00FE_1122, 4'b0100, 1'b0);
    put(pay(5), 4'b0000, 1'b0);
    put(pay(6), 4'b0000, 1'b0);
    send_frame(2, W_TERM0, 4'hF, 1'b0);
    exp_full(5, 1'b1, 1'b1);
    exp_full(2, 1'b1, 1'b0);
    exp_err++; exp_frm++;
    tests_run++;
    if (got.size() !== exp.size()) begin
      tests_failed++; $display("FAIL errctrl_count: got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== exp[i]) begin
        tests_failed++; $display("FAIL errctrl_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
`ifdef XGMII_RX_STATS_EN
    tests_run++;
    if (error_count !== 32'(exp_err)) begin
      tests_failed++; $display("FAIL errctrl_errcnt: got %0d want %0d", error_count, exp_err);
    end
`endif
  endtask

  task automatic test_valid_gaps();
    int bad_gap;
    start_test();
    send_frame(16, W_TERM0, 4'hF, 1'b1);
    exp_full(16, 1'b1, 1'b0);
    exp_frm++;
    tests_run++;
    if (got.size() !== exp.size()) begin
      tests_failed++; $display("FAIL gaps_count: got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== exp[i]) begin
        tests_failed++; $display("FAIL gaps_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
    bad_gap = 0;
    for (int i = 1; i < got_cyc.size(); i++)
      if (got_cyc[i] - got_cyc[i-1] != 2) bad_gap++;
    tests_run++;
    if (bad_gap !== 0) begin
      tests_failed++; $display("FAIL gaps_spacing: %0d beats not 2 cycles apart, want 0", bad_gap);
    end
  endtask

  task automatic test_bad_sfd();
    start_test();
    idles(2);
    put(W_START, 4'b0001, 1'b0);
    put(32'hD555_5554, 4'b0000, 1'b0);
    for (int i = 0; i < 16; i++) put(pay(i), 4'b0000, 1'b0);
    put(W_TERM0, 4'hF, 1'b0);
    idles(3);
    exp_err++;
    tests_run++;
    if (got.size() !== 0) begin
      tests_failed++; $display("FAIL badsfd_nobeats: got %0d beats want 0", got.size());
    end
`ifdef XGMII_RX_STATS_EN
    tests_run++;
    if (error_count !== 32'(exp_err)) begin
      tests_failed++; $display("FAIL badsfd_errcnt: got %0d want %0d", error_count, exp_err);
    end
`endif
    send_frame(16, W_TERM0, 4'hF, 1'b0);
    exp_full(16, 1'b1, 1'b0);
    exp_frm++;
    tests_run++;
    if (got.size() !== exp.size()) begin
      tests_failed++; $display("FAIL badsfd_next_count: got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== exp[i]) begin
        tests_failed++; $display("FAIL badsfd_next_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_zero_payload();
    start_test();
    send_frame(0, W_TERM0, 4'hF, 1'b0);
    exp_err++;
    tests_run++;
    if (got.size() !== 0) begin
      tests_failed++; $display("FAIL zero_payload: got %0d beats want 0", got.size());
    end
`ifdef XGMII_RX_STATS_EN
    tests_run++;
    if (error_count !== 32'(exp_err)) begin
      tests_failed++; $display("FAIL zero_errcnt: got %0d want %0d", error_count, exp_err);
    end
`endif
  endtask

  task automatic test_max_frame();
    start_test();
    send_frame(MAXW, W_TERM0, 4'hF, 1'b0);
    send_frame(MAXW + 1, W_TERM0, 4'hF, 1'b0);
    exp_full(MAXW, 1'b1, 1'b0);
    exp_full(MAXW, 1'b1, 1'b1);
    exp_frm++; exp_err++;
    tests_run++;
    if (got.size() !== exp.size()) begin
      tests_failed++; $display("FAIL maxlen_count: got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== exp[i]) begin
        tests_failed++; $display("FAIL maxlen_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_test();
    idles(2);
    put(W_START, 4'b0001, 1'b0);
    put(W_SFD, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) put(pay(i), 4'b0000, 1'b0);
    put(W_START, 4'b0001, 1'b0);
    put(W_SFD, 4'b0000, 1'b0);
    for (int i = 0; i < 2; i++) put(pay(i), 4'b0000, 1'b0);
    put(W_TERM0, 4'hF, 1'b0);
    idles(3);
    exp_full(3, 1'b1, 1'b1);
    exp_full(2, 1'b1, 1'b0);
    exp_err++; exp_frm++;
    tests_run++;
    if (got.size() !== exp.size()) begin
      tests_failed++; $display("FAIL b2b_count: got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== exp[i]) begin
        tests_failed++; $display("FAIL b2b_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
`ifdef XGMII_RX_STATS_EN
    tests_run++;
    if (error_count !== 32'(exp_err) || frame_count !== 32'(exp_frm)) begin
      tests_failed++;
      $display("FAIL b2b_counters: err=%0d frm=%0d want %0d %0d",
               error_count, frame_count, exp_err, exp_frm);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    start_test();
    idles(2);
    put(W_START, 4'b0001, 1'b0);
    put(W_SFD, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) put(pay(i), 4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b1; vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0; exp_frm = 0;
    send_frame(16, W_TERM0, 4'hF, 1'b0);
    exp_full(4, 1'b0, 1'b0);
    exp_full(16, 1'b1, 1'b0);
    exp_frm++;
    tests_run++;
    if (got.size() !== exp.size()) begin
      tests_failed++; $display("FAIL rstmid_count: got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== exp[i]) begin
        tests_failed++; $display("FAIL rstmid_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
`ifdef XGMII_RX_STATS_EN
    tests_run++;
    if (error_count !== 32'(exp_err) || frame_count !== 32'(exp_frm)) begin
      tests_failed++;
      $display("FAIL rstmid_counters: err=%0d frm=%0d want %0d %0d",
               error_count, frame_count, exp_err, exp_frm);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_frame64();
    test_partial_term();
    test_error_ctrl();
    test_valid_gaps();
    test_bad_sfd();
    test_zero_payload();
    test_max_frame();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/xgmii_rx_deframer.md
XGMII_RX_DEFRAMER -- requirements
Module: xgmii_rx_deframer

Interface
REQ-001 Parameter MAX_FRAME_WORDS, default 380, is the maximum number of payload words per frame; payload excludes preamble and SFD.
REQ-002 Port i_clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port i_xgmii_rxd, input, 32 bits: XGMII data; lane k occupies bits [8k+7:8k].
REQ-005 Port i_xgmii_rxc, input, 4 bits: XGMII control; bit k=1 marks lane k as a control character.
REQ-006 Port i_rx_valid, input, 1 bit: input word qualifier; words with i_rx_valid=0 SHALL be ignored with no state change (gearbox gaps).
REQ-007 Port o_axis_tdata, output, 32 bits: payload; byte 0 is in bits [7:0].
REQ-008 Port o_axis_tkeep, output, 4 bits: byte-valid mask.
REQ-009 Port o_axis_tvalid, output, 1 bit: beat valid; there is no tready and the block SHALL NOT be stalled.
REQ-010 Port o_axis_tlast, output, 1 bit: last beat of a frame.
REQ-011 Port o_axis_tuser, output, 1 bit: frame error, meaningful only when tlast=1.

Function
REQ-012 States SHALL be IDLE, PREAMBLE, DATA and DRAIN, advancing only on valid input words.
REQ-013 IDLE→PREAMBLE SHALL occur on rxd=0x555555FB with rxc=4'b0001; every other word SHALL hold IDLE.
REQ-014 PREAMBLE→DATA SHALL occur on rxd=0xD5555555 with rxc=4'b0000; any other word SHALL return the FSM to IDLE, silently drop the frame, and count one error.
REQ-015 In DATA, a word with rxc=0 SHALL be stored in a one-word hold register; the previous held word, if any, SHALL be emitted with tkeep=4'b1111, tlast=0.
REQ-016 Terminate detection: the lowest lane k with rxc[k]=1 and byte 0xFD.
- k=0: the held word SHALL be emitted with tlast=1, tkeep=1111.
- k>0: the held word SHALL be emitted; the next output cycle SHALL carry the current lanes 0..k-1 with tkeep=(1<<k)-1, tlast=1.
- Then →IDLE.
REQ-017 Output beats SHALL be registered: a beat appears one i_clk cycle after the input word that releases it; back-to-back tvalid SHALL be permitted.
REQ-018 In DATA, any control lane before the terminate lane that is not 0xFD (including 0xFE error and 0x07 idle) SHALL emit the held word with tlast=1, tuser=1, then →DRAIN.
REQ-019 In DATA, reaching MAX_FRAME_WORDS+1 payload words SHALL end the frame as in REQ-018.
REQ-020 In DATA, a start word (REQ-013 pattern) SHALL end the current frame as in REQ-018, then →PREAMBLE.
REQ-021 DRAIN→IDLE SHALL occur on the first word containing 0xFD or an all-idle word (rxc=1111, rxd=0x07070707); all other words SHALL be discarded.
REQ-022 A frame with zero payload words (SFD followed immediately by terminate) SHALL emit no beats and count one error.
REQ-023 Outputs are only o_axis_*; tuser SHALL be 0 on every beat with tlast=0.

Reset
REQ-024 Under i_reset=1, at the next edge the FSM SHALL be IDLE, the hold register empty, o_axis_tvalid/tlast/tuser=0, tkeep=0, tdata=0.
REQ-025 Reset mid-frame SHALL abandon the frame without emitting tlast.
REQ-026 Input SHALL be ignored while i_reset=1.

Configuration
REQ-027 With XGMII_RX_STATS_EN defined, the block SHALL provide two ports: o_frame_count[31:0] (good frames, incremented on tlast with tuser=0) and o_error_count[31:0] (REQ-014/018/019/020/022 events).
REQ-028 Both counters SHALL wrap and reset to 0.
REQ-029 Without XGMII_RX_STATS_EN, those ports and their logic SHALL be absent.

Structure
REQ-030 Package xgmii_pkg SHALL hold:
- constants XGMII_IDLE=0x07, XGMII_START=0xFB, XGMII_TERM=0xFD, XGMII_ERROR=0xFE;
- the preamble and SFD words;
- the FSM state enum.
REQ-031 Sub-module xgmii_term_detect, combinational, SHALL take rxd/rxc and return term_found, term_lane[1:0] and bad_ctrl.

Verification
REQ-032 Directed scenarios:
- 64-byte frame: idle ×2, 0x555555FB/0001, 0xD5555555/0000, 16 data words, 0x070707FD/1111 → 16 beats, tkeep=1111 throughout, tlast on the beat carrying 0x79F7EB93, tuser=0.
- Same frame ending with 0x07FDxxxx, rxc=1100, after word 16 → 17 beats, last beat tkeep=0011, tlast=1.
- 0xFE with rxc=0100 mid-payload → tlast with tuser=1 on the held word; following data dropped until the next idle; error_count=1.
- i_rx_valid toggled 1,0,1,0 throughout the 64-byte frame → identical beat sequence with tvalid gaps.
- Bad SFD 0xD5555554 → no beats; error_count=1; the next good frame is received normally.
- i_reset pulsed after 5 payload words, then a good frame → no tlast for the aborted frame; the good frame is intact.
